pinball_hole_tracker: RTL and testbench
=======================================

Name: pinball_hole_tracker

Overview:
- Parametrised hole-sensor front end for the pinball table. Replaces the fixed 8-hole sensor.
- Synchronises and debounces N raw hole sensors, then turns each new ball arrival into a single-cycle event.
- Tracks remaining balls with saturating multi-hit decrement, a sticky last-hit vector and a binary index.
- Gated by the top-level game FSM state; feeds the score and display logic.

Parameters:
- NUM_HOLES, 8, number of hole sensors (1..16).
- BALLS, 8, ball count loaded on reset and in RESET state.
- CNT_W, 4, width of ball_num; must hold BALLS.
- IDX_W, 3, width of hit_idx; must satisfy 2^IDX_W >= NUM_HOLES.
- DEBOUNCE, 4, consecutive synchronised-high cycles needed to accept a hit (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- ball  in  NUM_HOLES  raw hole sensors, asynchronous, active-high.
- state  in  3  game FSM state: RESET=0, WAIT=1, START=2, GET=3, OVER=4.
- ball_num  out  CNT_W  balls remaining.
- getball  out  NUM_HOLES  one-hot sticky vector of the last accepted hole.
- hit_idx  out  IDX_W  binary index of the last accepted hole.
- hit_valid  out  1  one-cycle pulse per accepted event cycle.
- balls_out  out  1  high while ball_num == 0.

Behaviour:
- Clock and reset: single clock, clk. rst_n is synchronous and active-low.
- On any clk edge with rst_n=0:
  - ball_num=BALLS, getball=0, hit_idx=0, hit_valid=0, balls_out=(BALLS==0).
  - All synchroniser, debounce and stable registers clear to 0.
- Per-hole pipeline, running in every game state:
  - 2-flop synchroniser produces sync[i].
  - Debounce counter (width clog2(DEBOUNCE+1)) increments while sync[i]=1 and saturates at DEBOUNCE. It clears to 0 the cycle sync[i]=0.
  - stable[i] is set when the counter reaches DEBOUNCE. It clears when sync[i]=0.
  - rise[i] = stable[i] & ~stable_d[i], one cycle per arrival.
- Latency: if ball[i] is sampled high at edge E and stays high, hit_valid and the output updates register at edge E+DEBOUNCE+2.
- Glitch rejection: a pulse shorter than DEBOUNCE synchronised cycles produces no event.
- Event acceptance:
  - Only when state==START and rise is nonzero. Rises in any other state are consumed and discarded, with no later replay.
  - hit_valid=1 for exactly one cycle per accepting cycle; otherwise 0.
  - getball = one-hot of the lowest-index rising hole. hit_idx = that index.
  - getball and hit_idx hold their values between events.
- Simultaneous rises in one cycle:
  - ball_num decrements by popcount(rise), saturating at 0 (no wrap).
  - getball and hit_idx report the lowest index only.
- State RESET:
  - ball_num reloads BALLS and getball clears to 0. hit_idx holds.
  - No events are accepted.
- balls_out is registered and equals (next ball_num == 0), so it updates on the same edge as ball_num.
- Any state change mid-debounce does not disturb the debounce counters.
- Reset mid-debounce discards the partial count.

Optional Feature:
- Macro: PINBALL_HOLE_MASK_EN.
- Defined: adds input hole_en[NUM_HOLES-1:0]. An event for hole i requires hole_en[i]=1 in the accepting cycle. Masked rises are discarded and do not reach getball or ball_num.
- Undefined: the port is absent and all holes are always enabled.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then state=RESET -> ball_num=8, getball=0, hit_valid=0, balls_out=0.
- Single hit: state=START, ball=8'b0000_0100 held 10 cycles -> exactly one hit_valid pulse at edge E+6. Then getball=0000_0100, hit_idx=2, ball_num=7.
- Glitch: ball[5] high for 3 cycles with DEBOUNCE=4 -> no hit_valid, ball_num unchanged.
- Simultaneous: ball=1001_0010 rising together in START -> one hit_valid, hit_idx=1, getball=0000_0010, ball_num drops by 3 (8->5).
- Saturation: ball_num=1, two holes rise together -> ball_num=0, balls_out=1. A further hit keeps ball_num=0.
- State gating: hit during WAIT -> no event. Switching to START while ball is still held -> still no event. Toggle RESET -> ball_num=8, getball=0.

Source files
------------

// File: rtl/pinball_hole_tracker.sv
// -----------------------------------------------------------------------------
// pinball_hole_tracker
//
// Front end for the N hole sensors of the pinball table. Each raw sensor goes
// through a 2-flop synchroniser and a saturating debounce counter. A new
// stable arrival becomes a single-cycle rise. Rises are accepted only while the
// game FSM is in START. Accepted rises decrement the remaining-ball count by
// the number of holes hit, saturating at zero, and latch the lowest hit hole.
//
// Optional feature: define PINBALL_HOLE_MASK_EN to add the hole_en input. An
// event on hole i then also needs hole_en[i] set in the accepting cycle.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   ball       raw hole sensors, asynchronous, active-high
//   state      game FSM state (RESET=0 WAIT=1 START=2 GET=3 OVER=4)
//   ball_num   balls remaining
//   getball    one-hot sticky vector of the last accepted hole
//   hit_idx    binary index of the last accepted hole
//   hit_valid  one-cycle pulse per accepting cycle
//   balls_out  high while ball_num == 0
//   hole_en    per-hole event enable (PINBALL_HOLE_MASK_EN only)
// -----------------------------------------------------------------------------
module pinball_hole_tracker #(
    parameter int NUM_HOLES = 8,
    parameter int BALLS     = 8,
    parameter int CNT_W     = 4,
    parameter int IDX_W     = 3,
    parameter int DEBOUNCE  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HOLES-1:0] ball,
    input  logic [2:0]           state,
`ifdef PINBALL_HOLE_MASK_EN
    input  logic [NUM_HOLES-1:0] hole_en,
`endif
    output logic [CNT_W-1:0]     ball_num,
    output logic [NUM_HOLES-1:0] getball,
    output logic [IDX_W-1:0]     hit_idx,
    output logic                 hit_valid,
    output logic                 balls_out
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(NUM_HOLES + 1);
    localparam int SW = (CNT_W > PW) ? CNT_W : PW;
    localparam logic [DW-1:0]    DEB_MAX    = DW'(DEBOUNCE);
    localparam logic [CNT_W-1:0] BALLS_INIT = CNT_W'(BALLS);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_WAIT  = 3'd1,
        ST_START = 3'd2,
        ST_GET   = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    // Number of set bits in a rise vector.
    function automatic logic [PW-1:0] popcount(input logic [NUM_HOLES-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Index of the lowest set bit (0 when the vector is empty).
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_HOLES-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_HOLES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NUM_HOLES-1:0]         sync1_r, sync2_r;
    logic [NUM_HOLES-1:0][DW-1:0] deb_cnt_r, deb_cnt_s;
    logic [NUM_HOLES-1:0]         stable_r, stable_s, stable_d_r;
    logic [NUM_HOLES-1:0]         rise_s, en_rise_s, low_bit_s;
    logic [PW-1:0]                pop_s;
    logic                         accept_s, reload_s;
    logic [CNT_W-1:0]             ball_num_s;

    // Debounce next-state: count up while synchronised high, clear on low.
    always_comb begin
        deb_cnt_s = '0;
        stable_s  = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (sync2_r[i]) begin
                if (deb_cnt_r[i] == DEB_MAX) begin
                    deb_cnt_s[i] = DEB_MAX;
                end else begin
                    deb_cnt_s[i] = deb_cnt_r[i] + DW'(1);
                end
                stable_s[i] = stable_r[i] | (deb_cnt_s[i] == DEB_MAX);
            end else begin
                deb_cnt_s[i] = '0;
                stable_s[i]  = 1'b0;
            end
        end
    end

    // Arrival edges, optional enable mask, and derived hit summaries.
    always_comb begin
        rise_s = stable_r & ~stable_d_r;
`ifdef PINBALL_HOLE_MASK_EN
        en_rise_s = rise_s & hole_en;
`else
        en_rise_s = rise_s;
`endif
        // Two's-complement trick isolates the lowest set bit.
        low_bit_s = en_rise_s & (~en_rise_s + NUM_HOLES'(1'b1));
        pop_s     = popcount(en_rise_s);
    end

    // Game-state gating: rises outside START are simply dropped.
    always_comb begin
        accept_s = 1'b0;
        reload_s = 1'b0;
        case (state)
            ST_RESET: reload_s = 1'b1;
            ST_START: accept_s = |en_rise_s;
            ST_WAIT, ST_GET, ST_OVER: begin
                accept_s = 1'b0;
                reload_s = 1'b0;
            end
            default: begin
                accept_s = 1'b0;
                reload_s = 1'b0;
            end
        endcase
    end

    // Next ball count: reload in RESET, saturating multi-hit decrement.
    always_comb begin
        ball_num_s = ball_num;
        if (reload_s) begin
            ball_num_s = BALLS_INIT;
        end else if (accept_s) begin
            if (SW'(ball_num) <= SW'(pop_s)) begin
                ball_num_s = '0;
            end else begin
                ball_num_s = ball_num - CNT_W'(pop_s);
            end
        end else begin
            ball_num_s = ball_num;
        end
    end

    // Per-hole synchroniser, debounce and edge-detect pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r    <= '0;
            sync2_r    <= '0;
            deb_cnt_r  <= '0;
            stable_r   <= '0;
            stable_d_r <= '0;
        end else begin
            sync1_r    <= ball;
            sync2_r    <= sync1_r;
            deb_cnt_r  <= deb_cnt_s;
            stable_r   <= stable_s;
            stable_d_r <= stable_r;
        end
    end

    // Registered outputs: count, sticky hit vector/index and event pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ball_num  <= BALLS_INIT;
            getball   <= '0;
            hit_idx   <= '0;
            hit_valid <= 1'b0;
            balls_out <= (BALLS_INIT == '0);
        end else begin
            ball_num  <= ball_num_s;
            balls_out <= (ball_num_s == '0);
            hit_valid <= accept_s;
            if (reload_s) begin
                getball <= '0;
            end else if (accept_s) begin
                getball <= low_bit_s;
                hit_idx <= lowest_idx(en_rise_s);
            end else begin
                getball <= getball;
                hit_idx <= hit_idx;
            end
        end
    end

endmodule

// File: tb/tb_pinball_hole_tracker.sv
// -----------------------------------------------------------------------------
// Testbench for pinball_hole_tracker (default parameters). Directed stimulus
// pushes the expected event (outputs plus arrival cycle) into a queue; an
// independent monitor pops and compares on every hit_valid pulse.
// -----------------------------------------------------------------------------
module tb_pinball_hole_tracker;

    logic       clk;
    logic       rst_n;
    logic [7:0] ball;
    logic [2:0] state;
    logic [3:0] ball_num;
    logic [7:0] getball;
    logic [2:0] hit_idx;
    logic       hit_valid;
    logic       balls_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] gb;
        int         idx;
        int         num;
        logic       out;
        int         cyc;
    } exp_t;

    exp_t q[$];

    pinball_hole_tracker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ball      (ball),
        .state     (state),
`ifdef PINBALL_HOLE_MASK_EN
        .hole_en   (8'hFF),
`endif
        .ball_num  (ball_num),
        .getball   (getball),
        .hit_idx   (hit_idx),
        .hit_valid (hit_valid),
        .balls_out (balls_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to check event latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a pattern in START long enough to register, then release.
    task automatic hit(input logic [7:0] pat, input logic [7:0] gb, input int idx,
                       input int num, input logic out);
        exp_t e;
        e.gb  = gb;
        e.idx = idx;
        e.num = num;
        e.out = out;
        e.cyc = cyc + 7;
        q.push_back(e);
        ball = pat;
        step(10);
        ball = 8'h00;
        step(8);
    endtask

    // Monitor: every hit_valid pulse must match the next expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && hit_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hit_valid actual=1 required=0 cycle=%0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("ev_cycle",     cyc,       e.cyc);
                    chk("ev_getball",   getball,   e.gb);
                    chk("ev_hit_idx",   hit_idx,   e.idx);
                    chk("ev_ball_num",  ball_num,  e.num);
                    chk("ev_balls_out", balls_out, e.out);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        ball  = 8'h00;
        state = 3'd0;
        step(2);
        rst_n = 1'b1;
        chk("rst_ball_num",  ball_num,  8);
        chk("rst_getball",   getball,   0);
        chk("rst_hit_idx",   hit_idx,   0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_balls_out", balls_out, 0);
        step(2);

        // Single hit on hole 2.
        state = 3'd2;
        hit(8'b0000_0100, 8'b0000_0100, 2, 7, 1'b0);

        // Glitch of 3 cycles on hole 5: rejected.
        ball = 8'b0010_0000;
        step(3);
        ball = 8'h00;
        step(10);
        chk("glitch_ball_num", ball_num, 7);
        chk("glitch_getball",  getball,  8'b0000_0100);

        // RESET reloads count, clears getball, keeps hit_idx.
        state = 3'd0;
        step(2);
        chk("reload_ball_num", ball_num, 8);
        chk("reload_getball",  getball,  0);
        chk("reload_hit_idx",  hit_idx,  2);
        state = 3'd2;

        // Simultaneous rise: lowest index reported, count drops by 3.
        hit(8'b1001_0010, 8'b0000_0010, 1, 5, 1'b0);
        // Four holes: 5 -> 1.
        hit(8'b0000_1111, 8'b0000_0001, 0, 1, 1'b0);
        // Two holes with one ball left: saturate to 0.
        hit(8'b0110_0000, 8'b0010_0000, 5, 0, 1'b1);
        // Further hit keeps 0.
        hit(8'b1000_0000, 8'b1000_0000, 7, 0, 1'b1);
        chk("sat_balls_out", balls_out, 1);

        // Reload, then a hit during WAIT that is held into START: no event.
        state = 3'd0;
        step(2);
        chk("reload2_balls_out", balls_out, 0);
        state = 3'd1;
        ball  = 8'b0000_1000;
        step(10);
        state = 3'd2;
        step(10);
        ball = 8'h00;
        step(8);
        chk("gate_ball_num",  ball_num,  8);
        chk("gate_getball",   getball,   0);
        chk("gate_balls_out", balls_out, 0);

        // Released hole re-arrives in START: accepted normally.
        hit(8'b0000_1000, 8'b0000_1000, 3, 7, 1'b0);

        step(5);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
